// File: rtl/subclk_pkg.sv
// Shared types, default sizes and the reset-divisor rule for subclk_gen_bank.
package subclk_pkg;

    localparam int unsigned DEF_N_CH  = 4;
    localparam int unsigned DEF_DIV_W = 8;
    localparam int unsigned DEF_CH_W  = (DEF_N_CH > 1) ? $clog2(DEF_N_CH) : 1;

    typedef logic [DEF_DIV_W-1:0] div_t;
    typedef logic [DEF_CH_W-1:0]  ch_t;

    // Channel i resets to 2^(i+1), saturating to 2^w-1 when that needs more than w bits.
    function automatic logic [31:0] default_div(input int unsigned i, input int unsigned w);
        if (i + 1 < w) return 32'(1) << (i + 1);
        return (32'(1) << w) - 32'(1);
    endfunction

endpackage

// File: rtl/subclk_channel.sv
// One sub-clock channel: counter, active/pending divisor and registered subclk/tick.
// SUBCLK_PHASE_EN adds a per-write start phase loaded when a divisor is applied or on sync.
module subclk_channel
    import subclk_pkg::*;
#(
    parameter int unsigned      DIV_W   = DEF_DIV_W,
    parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(2)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
`ifdef SUBCLK_PHASE_EN
    input  logic [DIV_W-1:0] wr_phase,
`endif
    output logic             pending,
    output logic             subclk,
    output logic             tick
);

    logic [DIV_W-1:0] cnt, div, pend_div;
    logic [DIV_W-1:0] cnt_n, div_n, start;
    logic             wrap, apply, sub_n, tick_n;
`ifdef SUBCLK_PHASE_EN
    logic [DIV_W-1:0] phase, pend_phase, phase_n;
`endif

    always_comb begin
        wrap  = (div == '0) ? 1'b0 : (cnt == div - 1'b1);
        // Disabled and /1 channels have no period to protect, so they apply at once.
        apply = pending && (sync || wrap || (div == '0) || (div == DIV_W'(1)));
        div_n = apply ? pend_div : div;
`ifdef SUBCLK_PHASE_EN
        phase_n = apply ? pend_phase : phase;
        start   = (phase_n >= div_n) ? '0 : phase_n;
`else
        start   = '0;
`endif
        if (sync || apply)
            cnt_n = start;
        else if (wrap || (div == '0))
            cnt_n = '0;
        else
            cnt_n = cnt + 1'b1;

        // Outputs derive from next-state values so they register in step with cnt.
        if (div_n == '0) begin
            sub_n  = 1'b1;
            tick_n = 1'b0;
        end else begin
            sub_n  = (cnt_n < (div_n - (div_n >> 1)));
            tick_n = (cnt_n == div_n - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            div        <= RST_DIV;
            pend_div   <= '0;
            pending    <= 1'b0;
            subclk     <= 1'b1;
            tick       <= 1'b0;
`ifdef SUBCLK_PHASE_EN
            phase      <= '0;
            pend_phase <= '0;
`endif
        end else begin
            cnt    <= cnt_n;
            div    <= div_n;
            subclk <= sub_n;
            tick   <= tick_n;
`ifdef SUBCLK_PHASE_EN
            phase  <= phase_n;
`endif
            // A write is only accepted while not pending, so it never collides with apply.
            if (wr) begin
                pending    <= 1'b1;
                pend_div   <= wr_div;
`ifdef SUBCLK_PHASE_EN
                pend_phase <= wr_phase;
`endif
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/subclk_gen_bank.sv
// N-channel programmable sub-clock generator: config decode, cfg_ready mux, channel array.
// Optional feature macro: SUBCLK_PHASE_EN (adds cfg_phase start-phase input).
module subclk_gen_bank
    import subclk_pkg::*;
#(
    parameter  int unsigned N_CH  = DEF_N_CH,
    parameter  int unsigned DIV_W = DEF_DIV_W,
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
`ifdef SUBCLK_PHASE_EN
    input  logic [DIV_W-1:0] cfg_phase,
`endif
    output logic [N_CH-1:0]  subclk,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0]         pending;
    logic [N_CH-1:0]         wr;
    logic [(1<<CH_W)-1:0]    pend_ext;

    // Out-of-range channel indices read as never pending: accepted and discarded.
    for (genvar g = 0; g < (1 << CH_W); g++) begin : g_pext
        if (g < N_CH) begin : g_real
            assign pend_ext[g] = pending[g];
        end else begin : g_pad
            assign pend_ext[g] = 1'b0;
        end
    end

    assign cfg_ready = !pend_ext[cfg_ch];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        subclk_channel #(
            .DIV_W   (DIV_W),
            .RST_DIV (DIV_W'(default_div(g, DIV_W)))
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .sync     (sync),
            .wr       (wr[g]),
            .wr_div   (cfg_div),
`ifdef SUBCLK_PHASE_EN
            .wr_phase (cfg_phase),
`endif
            .pending  (pending[g]),
            .subclk   (subclk[g]),
            .tick     (tick[g])
        );
    end

endmodule
